// File: rtl/denise_pkg.sv
`default_nettype none
// ============================================================================
// Module      : denise_pkg
// Description : Shared constants for the Denise sprite channel: register
//               addresses, resolution and sprite-width encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package denise_pkg;

    // Register offsets within one sprite channel
    localparam logic [1:0] ADDR_POS  = 2'b00;
    localparam logic [1:0] ADDR_CTL  = 2'b01;
    localparam logic [1:0] ADDR_DATA = 2'b10;
    localparam logic [1:0] ADDR_DATB = 2'b11;

    // Pixel-rate selection; any value with bit 1 set is super-hires
    localparam logic [1:0] RES_LORES = 2'b00;
    localparam logic [1:0] RES_HIRES = 2'b01;
    localparam logic [1:0] RES_SHRES = 2'b10;

    // Fetch width selection; both middle codes mean 32 pixels
    localparam logic [1:0] SPRW_16     = 2'b00;
    localparam logic [1:0] SPRW_32     = 2'b01;
    localparam logic [1:0] SPRW_32_ALT = 2'b10;
    localparam logic [1:0] SPRW_64     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_SHIFT = 2'b10
    } spr_state_e;

    // Sprite width in pixels, clamped to the physical shifter width
    function automatic int unsigned sprw_pixels(input logic [1:0] sprw,
                                                input int unsigned dw);
        int unsigned px;
        case (sprw)
            SPRW_16: px = 16;
            SPRW_64: px = 64;
            default: px = 32;
        endcase
        return (px > dw) ? dw : px;
    endfunction

    // Last divider value before a shift tick: 4, 2 or 1 clocks per pixel
    function automatic logic [1:0] res_div_max(input logic [1:0] res);
        logic [1:0] m;
        case (res)
            RES_LORES: m = 2'd3;
            RES_HIRES: m = 2'd1;
            default:   m = 2'd0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/denise_sprite_serial.sv
`default_nettype none
// ============================================================================
// Module      : denise_sprite_serial
// Description : Dual-plane DW-bit sprite shift register with parallel load,
//               per-tick left shift and remaining-pixel counter.
// Revision    : 1.0 - initial release
// ============================================================================
module denise_sprite_serial
    import denise_pkg::*;
#(
    parameter int DW = 64,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          load,
    input  logic          tick,
    input  logic [DW-1:0] load_a,
    input  logic [DW-1:0] load_b,
    input  logic [CW-1:0] load_cnt,
    output logic          msb_a,
    output logic          msb_b,
    output logic          last
);

    logic [DW-1:0] shift_a_q, shift_a_d;
    logic [DW-1:0] shift_b_q, shift_b_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Clear beats load, load beats shift; counter never wraps below zero
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        cnt_d     = cnt_q;
        if (clr) begin
            shift_a_d = '0;
            shift_b_d = '0;
            cnt_d     = '0;
        end else if (load) begin
            shift_a_d = load_a;
            shift_b_d = load_b;
            cnt_d     = load_cnt;
        end else if (tick && (cnt_q != '0)) begin
            shift_a_d = {shift_a_q[DW-2:0], 1'b0};
            shift_b_d = {shift_b_q[DW-2:0], 1'b0};
            cnt_d     = cnt_q - CW'(1);
        end
    end

    // Shifter and counter state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            cnt_q     <= '0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign msb_a = shift_a_q[DW-1];
    assign msb_b = shift_b_q[DW-1];
    // The tick that consumes the final pixel
    assign last  = tick && (cnt_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/denise_sprite_shifter_gen.sv
`default_nettype none
// ============================================================================
// Module      : denise_sprite_shifter_gen
// Description : One Denise sprite channel: POS/CTL/DATA/DATB registers,
//               28 MHz hstart comparator, arm/shift FSM, pixel-rate divider
//               and output pipeline feeding the priority/colour mux.
// Revision    : 1.0 - initial release
// ============================================================================
module denise_sprite_shifter_gen
    import denise_pkg::*;
#(
    parameter int DW   = 64,
    parameter int HPW  = 11,
    parameter int PIPE = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clk7_en,
    input  logic           aen,
    input  logic [1:0]     address,
    input  logic [15:0]    data_in,
    input  logic [47:0]    chip48,
    input  logic [1:0]     spr_width,
    input  logic [1:0]     res,
    input  logic [HPW-1:0] hpos,
    input  logic           hmsb_ign,
    output logic [1:0]     sprdata,
    output logic           attach,
    output logic           active
);

    localparam int CW = $clog2(DW + 1);

    logic [HPW-1:0] hstart_q, hstart_d;
    logic           attach_q, attach_d;
    logic [DW-1:0]  hold_a_q, hold_a_d;
    logic [DW-1:0]  hold_b_q, hold_b_d;
    spr_state_e     state_q, state_d;
    logic [1:0]     div_q, div_d;

    logic           w_wr, w_pos_wr, w_ctl_wr, w_data_wr, w_datb_wr;
    logic           w_match, w_tick, w_load, w_clr, w_last;
    logic           w_msb_a, w_msb_b;
    logic [63:0]    w_fill64;
    logic [DW-1:0]  w_fill;
    logic [1:0]     w_div_max;
    logic [CW-1:0]  w_load_cnt;
    logic [1:0]     w_pix;
    logic           w_act;

    assign w_wr      = clk7_en && aen;
    assign w_pos_wr  = w_wr && (address == ADDR_POS);
    assign w_ctl_wr  = w_wr && (address == ADDR_CTL);
    assign w_data_wr = w_wr && (address == ADDR_DATA);
    assign w_datb_wr = w_wr && (address == ADDR_DATB);

    // Bus word in the top 16 bits, extra fetch bits below it, zero padding last
    always_comb begin
        w_fill64 = {data_in, 48'h0};
        case (spr_width)
            SPRW_16: w_fill64 = {data_in, 48'h0};
            SPRW_64: w_fill64 = {data_in, chip48};
            default: w_fill64 = {data_in, chip48[47:32], 32'h0};
        endcase
    end

    // Narrower shifters keep the leading pixels, which clamps the width
    assign w_fill = w_fill64[63 -: DW];

    // Register file next values; all writes land on the write edge
    always_comb begin
        hstart_d = hstart_q;
        attach_d = attach_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        if (w_pos_wr) begin
            hstart_d[HPW-1:3] = data_in[HPW-4:0];
        end
        if (w_ctl_wr) begin
            attach_d       = data_in[7];
            hstart_d[2]    = data_in[0];
            hstart_d[1:0]  = data_in[4:3];
        end
        if (w_data_wr) begin
            hold_a_d = w_fill;
        end
        if (w_datb_wr) begin
            hold_b_d = w_fill;
        end
    end

    // Full 28 MHz compare every clock; MSB optionally ignored
    assign w_match = (hpos[HPW-2:0] == hstart_q[HPW-2:0]) &&
                     (hmsb_ign || (hpos[HPW-1] == hstart_q[HPW-1]));

    assign w_div_max  = res_div_max(res);
    assign w_tick     = (state_q == ST_SHIFT) && (div_q >= w_div_max);
    assign w_load_cnt = CW'(sprw_pixels(spr_width, DW));

    // Next state; CTL write disarms from anywhere, match (re)loads the shifters
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_clr   = 1'b0;
        if (w_ctl_wr) begin
            state_d = ST_IDLE;
            w_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_data_wr) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_match) begin
                        w_load  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_match) begin
                        w_load = 1'b1;
                    end else if (w_last) begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Divider restarts at every load so the first pixel gets a full period
    always_comb begin
        div_d = 2'd0;
        if ((state_q == ST_SHIFT) && !w_load && !w_clr) begin
            div_d = w_tick ? 2'd0 : div_q + 2'd1;
        end
    end

    // Channel registers, FSM state and divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hstart_q <= '0;
            attach_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            state_q  <= ST_IDLE;
            div_q    <= 2'd0;
        end else begin
            hstart_q <= hstart_d;
            attach_q <= attach_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            state_q  <= state_d;
            div_q    <= div_d;
        end
    end

    denise_sprite_serial #(
        .DW (DW),
        .CW (CW)
    ) u_serial (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_clr),
        .load     (w_load),
        .tick     (w_tick),
        .load_a   (hold_a_q),
        .load_b   (hold_b_q),
        .load_cnt (w_load_cnt),
        .msb_a    (w_msb_a),
        .msb_b    (w_msb_b),
        .last     (w_last)
    );

    // The shifter itself is the first output stage; PIPE-1 more follow
    assign w_pix = (state_q == ST_SHIFT) ? {w_msb_b, w_msb_a} : 2'b00;
    assign w_act = (state_q == ST_SHIFT);

    generate
        if (PIPE <= 1) begin : g_pipe_direct
            assign sprdata = w_pix;
            assign active  = w_act;
        end else begin : g_pipe_regs
            localparam int NREG = PIPE - 1;
            logic [NREG-1:0][1:0] pix_q, pix_d;
            logic [NREG-1:0]      act_q, act_d;

            // Delay line shared by pixel and active so they stay aligned
            always_comb begin
                pix_d    = pix_q;
                act_d    = act_q;
                pix_d[0] = w_pix;
                act_d[0] = w_act;
                for (int i = 1; i < NREG; i++) begin
                    pix_d[i] = pix_q[i-1];
                    act_d[i] = act_q[i-1];
                end
            end

            // Output pipeline registers
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pix_q <= '0;
                    act_q <= '0;
                end else begin
                    pix_q <= pix_d;
                    act_q <= act_d;
                end
            end

            assign sprdata = pix_q[NREG-1];
            assign active  = act_q[NREG-1];
        end
    endgenerate

    assign attach = attach_q;

endmodule
`default_nettype wire

// File: tb/tb_denise_sprite_shifter_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_denise_sprite_shifter_gen
// Description : Self-checking bench for denise_sprite_shifter_gen: table of
//               sprite configurations plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_denise_sprite_shifter_gen;

    localparam logic [1:0] A_POS  = 2'b00;
    localparam logic [1:0] A_CTL  = 2'b01;
    localparam logic [1:0] A_DATA = 2'b10;
    localparam logic [1:0] A_DATB = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        clk7_en;
    logic        aen;
    logic [1:0]  address;
    logic [15:0] data_in;
    logic [47:0] chip48;
    logic [1:0]  spr_width;
    logic [1:0]  res;
    logic [10:0] hpos;
    logic        hmsb_ign;
    logic [1:0]  sprdata;
    logic        attach;
    logic        active;

    denise_sprite_shifter_gen #(
        .DW   (64),
        .HPW  (11),
        .PIPE (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk7_en   (clk7_en),
        .aen       (aen),
        .address   (address),
        .data_in   (data_in),
        .chip48    (chip48),
        .spr_width (spr_width),
        .res       (res),
        .hpos      (hpos),
        .hmsb_ign  (hmsb_ign),
        .sprdata   (sprdata),
        .attach    (attach),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  res;
        logic [1:0]  sprw;
        logic [15:0] ctl;
        logic [15:0] data;
        logic [15:0] datb;
        logic [47:0] chip;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        int          first;
        int          hold;
        int          len;
        logic        exp_att;
    } vec_t;

    vec_t vecs [6];

    int n_checks;
    int n_pass;
    int first_seen;
    int act_cnt;
    int mism;
    int idx;
    int p;
    logic       exp_act;
    logic [1:0] exp_pix;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        address = a;
        data_in = d;
        aen     = 1'b1;
        clk7_en = 1'b1;
        step();
        aen     = 1'b0;
        clk7_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{res:2'b00, sprw:2'b00, ctl:16'h0000, data:16'h8001, datb:16'h0000,
                    chip:48'h0, exp_a:64'h8001_0000_0000_0000, exp_b:64'h0,
                    first:1, hold:4, len:64, exp_att:1'b0};
        vecs[1] = '{res:2'b10, sprw:2'b11, ctl:16'h0000, data:16'hFFFF, datb:16'h0000,
                    chip:48'hFFFF_FFFF_FFFF, exp_a:64'hFFFF_FFFF_FFFF_FFFF,
                    exp_b:64'h0000_FFFF_FFFF_FFFF, first:1, hold:1, len:64, exp_att:1'b0};
        vecs[2] = '{res:2'b00, sprw:2'b00, ctl:16'h0018, data:16'h8001, datb:16'h0000,
                    chip:48'h0, exp_a:64'h8001_0000_0000_0000, exp_b:64'h0,
                    first:4, hold:4, len:64, exp_att:1'b0};
        vecs[3] = '{res:2'b01, sprw:2'b01, ctl:16'h0000, data:16'hA5C3, datb:16'h0F0F,
                    chip:48'h1234_5678_9ABC, exp_a:64'hA5C3_1234_0000_0000,
                    exp_b:64'h0F0F_1234_0000_0000, first:1, hold:2, len:64, exp_att:1'b0};
        vecs[4] = '{res:2'b11, sprw:2'b10, ctl:16'h0000, data:16'h0001, datb:16'h8000,
                    chip:48'hFFFF_AAAA_5555, exp_a:64'h0001_FFFF_0000_0000,
                    exp_b:64'h8000_FFFF_0000_0000, first:1, hold:1, len:32, exp_att:1'b0};
        vecs[5] = '{res:2'b01, sprw:2'b00, ctl:16'h0080, data:16'h1234, datb:16'hF00F,
                    chip:48'hFFFF_FFFF_FFFF, exp_a:64'h1234_0000_0000_0000,
                    exp_b:64'hF00F_0000_0000_0000, first:1, hold:2, len:32, exp_att:1'b1};

        reset_n   = 1'b0;
        clk7_en   = 1'b0;
        aen       = 1'b0;
        address   = 2'b00;
        data_in   = 16'h0;
        chip48    = 48'h0;
        spr_width = 2'b00;
        res       = 2'b00;
        hpos      = 11'h0;
        hmsb_ign  = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_sprdata", int'(sprdata), 0);
        chk("reset_active",  int'(active),  0);
        chk("reset_attach",  int'(attach),  0);
        reset_n = 1'b1;
        step();

        // Table-driven sprite configurations, hstart = 0x200 (+fine)
        for (int v = 0; v < 6; v++) begin
            res       = vecs[v].res;
            spr_width = vecs[v].sprw;
            chip48    = vecs[v].chip;
            hmsb_ign  = 1'b0;
            hpos      = 11'h0;
            wr(A_POS,  16'h0040);
            wr(A_CTL,  vecs[v].ctl);
            wr(A_DATB, vecs[v].datb);
            wr(A_DATA, vecs[v].data);
            chk($sformatf("v%0d_attach", v), int'(attach), int'(vecs[v].exp_att));
            hpos       = 11'h200;
            first_seen = -1;
            act_cnt    = 0;
            mism       = 0;
            for (int n = 1; n <= 90; n++) begin
                step();
                hpos    = hpos + 11'd1;
                idx     = n - vecs[v].first;
                exp_act = (idx >= 0) && (idx < vecs[v].len);
                exp_pix = 2'b00;
                if (exp_act) begin
                    p       = idx / vecs[v].hold;
                    exp_pix = {vecs[v].exp_b[63-p], vecs[v].exp_a[63-p]};
                end
                if (active === 1'b1) begin
                    act_cnt++;
                    if (first_seen < 0) first_seen = n;
                end
                if (sprdata !== exp_pix) mism++;
            end
            chk($sformatf("v%0d_first_pixel_clk", v), first_seen, vecs[v].first);
            chk($sformatf("v%0d_active_clks", v), act_cnt, vecs[v].len);
            chk($sformatf("v%0d_pixel_mismatches", v), mism, 0);
        end

        // Reset in the middle of a running sprite
        res       = 2'b00;
        spr_width = 2'b00;
        chip48    = 48'h0;
        hpos      = 11'h0;
        wr(A_POS,  16'h0040);
        wr(A_CTL,  16'h0080);
        wr(A_DATB, 16'h0000);
        wr(A_DATA, 16'hFFFF);
        hpos = 11'h200;
        for (int n = 1; n <= 6; n++) begin
            step();
            hpos = hpos + 11'd1;
        end
        chk("rst_pre_active", int'(active), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_sprdata", int'(sprdata), 0);
        chk("rst_async_active",  int'(active),  0);
        step();
        reset_n = 1'b1;
        chk("rst_attach_cleared", int'(attach), 0);
        hpos    = 11'h0;
        act_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            hpos = hpos + 11'd1;
            if (active !== 1'b0 || sprdata !== 2'b00) act_cnt++;
        end
        chk("rst_idle_quiet", act_cnt, 0);
        wr(A_POS,  16'h0040);
        wr(A_CTL,  16'h0000);
        wr(A_DATA, 16'h8001);
        hpos = 11'h200;
        step();
        hpos = hpos + 11'd1;
        chk("rst_rearm_pix",    int'(sprdata), 1);
        chk("rst_rearm_active", int'(active),  1);

        // CTL write aborts a running sprite and disarms
        for (int n = 2; n <= 5; n++) begin
            step();
            hpos = hpos + 11'd1;
        end
        wr(A_CTL, 16'h0000);
        chk("ctl_abort_active",  int'(active),  0);
        chk("ctl_abort_sprdata", int'(sprdata), 0);
        hpos    = 11'h1FC;
        act_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            hpos = hpos + 11'd1;
            if (active !== 1'b0) act_cnt++;
        end
        chk("disarm_quiet", act_cnt, 0);

        // Match during SHIFT restarts the pattern from the first pixel
        wr(A_DATA, 16'h8000);
        hpos = 11'h200;
        for (int n = 1; n <= 10; n++) begin
            step();
            hpos = hpos + 11'd1;
        end
        chk("retrig_before", int'(sprdata), 0);
        hpos = 11'h200;
        step();
        hpos = hpos + 11'd1;
        chk("retrig_restart_pix", int'(sprdata), 1);
        act_cnt = 1;
        for (int n = 12; n <= 90; n++) begin
            step();
            hpos = hpos + 11'd1;
            if (active === 1'b1) act_cnt++;
        end
        chk("retrig_active_clks", act_cnt, 64);

        // DATA write on the match edge: old holding value is shown
        hpos = 11'h0;
        wr(A_CTL,  16'h0000);
        wr(A_DATB, 16'h0000);
        wr(A_DATA, 16'h00FF);
        address = A_DATA;
        data_in = 16'hFF00;
        aen     = 1'b1;
        clk7_en = 1'b1;
        hpos    = 11'h200;
        step();
        aen     = 1'b0;
        clk7_en = 1'b0;
        hpos    = hpos + 11'd1;
        chk("same_edge_first_pix", int'(sprdata), 0);
        chk("same_edge_active",    int'(active),  1);
        for (int n = 2; n <= 33; n++) begin
            step();
            hpos = hpos + 11'd1;
        end
        chk("same_edge_pix8", int'(sprdata), 1);
        for (int n = 34; n <= 70; n++) begin
            step();
            hpos = hpos + 11'd1;
        end
        chk("same_edge_done", int'(active), 0);

        // hstart MSB ignore: hpos 0x600 against hstart 0x200
        hmsb_ign = 1'b0;
        hpos     = 11'h600;
        step();
        step();
        chk("msb_no_ignore_quiet", int'(active), 0);
        hmsb_ign = 1'b1;
        step();
        hpos = hpos + 11'd1;
        chk("msb_ignore_new_data", int'(sprdata), 1);
        chk("msb_ignore_active",   int'(active),  1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
